memory_arbiter: RTL

- Shares the single 8-bit memory port between two requesters:
  - the control unit's memory sequencing (CPU side, fetch and execute accesses);
  - the external program loader/debug port (LDR side).
- Sits between both requesters and the memory macro.
- Serialises accesses, latches each winner's command, and returns read data with a one-cycle ack pulse.
- Supports a loader lock so the loader can burst-program memory while the CPU is held off.

---
 rtl/memory_arbiter.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/memory_arbiter.sv
// -----------------------------------------------------------------------------
// memory_arbiter
//
// Shares one memory port between the CPU memory sequencer and the external
// program loader / debug port. Accesses are serialised through a four-state
// FSM (IDLE -> ISSUE -> WAIT -> ACK). In IDLE the winner's command is latched.
// ISSUE strobes mem_en for exactly one cycle. WAIT covers the remaining memory
// latency. ACK returns read data and a one-cycle ack to the winner.
//
// While ldr_lock is high the CPU is not a candidate, so the loader can
// burst-program memory without interleaved CPU traffic.
//
// Ports:
//   clock, reset_n               clock (posedge); synchronous active-low reset
//   cpu_req/we/addr/wdata        CPU command; req is a level held until cpu_ack
//   cpu_ack, cpu_rdata           CPU completion pulse and registered read data
//   ldr_req/we/addr/wdata        loader command; req is a level held until ldr_ack
//   ldr_lock                     holds off CPU requests while high
//   ldr_ack, ldr_rdata           loader completion pulse and registered read data
//   mem_en/we/addr/wdata         memory strobe and command; all zero when idle
//   mem_rdata                    memory read data, MEM_LATENCY cycles after mem_en
//   owner                        requester of current/last transaction (0 CPU, 1 LDR)
//   busy                         high whenever the FSM is not in IDLE
// -----------------------------------------------------------------------------
module memory_arbiter #(
    parameter int ADDR_WIDTH      = 8,
    parameter int DATA_WIDTH      = 8,
    parameter int MEM_LATENCY     = 1,
    parameter int LOADER_PRIORITY = 0
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    input  logic                  ldr_req,
    input  logic                  ldr_we,
    input  logic [ADDR_WIDTH-1:0] ldr_addr,
    input  logic [DATA_WIDTH-1:0] ldr_wdata,
    input  logic                  ldr_lock,
    output logic                  ldr_ack,
    output logic [DATA_WIDTH-1:0] ldr_rdata,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  owner,
    output logic                  busy
);

    localparam int                   CNT_WIDTH = 4;
    localparam logic [CNT_WIDTH-1:0] LAT_LOAD  = CNT_WIDTH'(MEM_LATENCY - 1);
    localparam logic                 PRIO_LDR  = (LOADER_PRIORITY != 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_last_owner;
    logic                  r_owner;
    logic                  r_busy;
    logic                  r_cmd_we;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic                  r_mem_en;
    logic                  r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [DATA_WIDTH-1:0] r_mem_wdata;
    logic                  r_cpu_ack;
    logic                  r_ldr_ack;
    logic [DATA_WIDTH-1:0] r_cpu_rdata;
    logic [DATA_WIDTH-1:0] r_ldr_rdata;

    logic                  w_cpu_cand;
    logic                  w_ldr_cand;
    logic                  w_grant;
    logic                  w_grant_ldr;
    logic                  w_enter_ack;
    logic                  w_sel_we;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;

    // Arbitration: pick the winner among the current candidates and mux its command.
    always_comb begin
        w_cpu_cand  = cpu_req & ~ldr_lock;
        w_ldr_cand  = ldr_req;
        w_grant     = (r_state == ST_IDLE) & (w_cpu_cand | w_ldr_cand);
        // On a tie the loader wins when it has priority, or when the CPU had
        // the last turn (round-robin hands the port to the other requester).
        w_grant_ldr = w_ldr_cand & (~w_cpu_cand | PRIO_LDR | ~r_last_owner);
        w_sel_we    = cpu_we;
        w_sel_addr  = cpu_addr;
        w_sel_wdata = cpu_wdata;
        if (w_grant_ldr) begin
            w_sel_we    = ldr_we;
            w_sel_addr  = ldr_addr;
            w_sel_wdata = ldr_wdata;
        end else begin
            w_sel_we    = cpu_we;
            w_sel_addr  = cpu_addr;
            w_sel_wdata = cpu_wdata;
        end
    end

    // Next-state logic of the access sequencer.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_next = ST_ISSUE;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (MEM_LATENCY > 1) begin
                    w_state_next = ST_WAIT;
                end else begin
                    w_state_next = ST_ACK;
                end
            end
            ST_WAIT: begin
                // Counter holds the WAIT cycles still to go including this one.
                if (r_cnt <= 4'd1) begin
                    w_state_next = ST_ACK;
                end else begin
                    w_state_next = ST_WAIT;
                end
            end
            ST_ACK: begin
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        w_enter_ack = (w_state_next == ST_ACK);
    end

    // State, latched command, latency counter and all registered outputs.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
            r_owner      <= 1'b0;
            r_busy       <= 1'b0;
            r_cmd_we     <= 1'b0;
            r_cnt        <= '0;
            r_mem_en     <= 1'b0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_cpu_ack    <= 1'b0;
            r_ldr_ack    <= 1'b0;
            r_cpu_rdata  <= '0;
            r_ldr_rdata  <= '0;
        end else begin
            r_state  <= w_state_next;
            r_busy   <= (w_state_next != ST_IDLE);
            r_mem_en <= w_grant;
            // The memory command registers double as the address/data latch:
            // nothing after the issue cycle needs them, so they return to zero.
            if (w_grant) begin
                r_cmd_we     <= w_sel_we;
                r_mem_we     <= w_sel_we;
                r_mem_addr   <= w_sel_addr;
                r_mem_wdata  <= w_sel_wdata;
                r_owner      <= w_grant_ldr;
                r_last_owner <= w_grant_ldr;
            end else begin
                r_mem_we     <= 1'b0;
                r_mem_addr   <= '0;
                r_mem_wdata  <= '0;
            end
            if (r_state == ST_ISSUE) begin
                r_cnt <= LAT_LOAD;
            end else if (r_state == ST_WAIT) begin
                r_cnt <= r_cnt - 4'd1;
            end
            r_cpu_ack <= w_enter_ack & ~r_owner;
            r_ldr_ack <= w_enter_ack & r_owner;
            // The edge entering ACK is MEM_LATENCY cycles after mem_en: data is valid.
            if (w_enter_ack && !r_cmd_we) begin
                if (r_owner) begin
                    r_ldr_rdata <= mem_rdata;
                end else begin
                    r_cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign ldr_ack   = r_ldr_ack;
    assign ldr_rdata = r_ldr_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign owner     = r_owner;
    assign busy      = r_busy;

endmodule
